// File: rtl/mult_stream_sequencer.sv
// mult_stream_sequencer
// ---------------------
// Valid/ready streaming front-end for a sequential shift-add multiplier that
// takes a one-cycle start pulse and has no done signal. The block accepts one
// operand pair at a time and registers the operands onto the multiplier
// inputs. It then pulses start and counts out the fixed multiplier latency.
// Next it captures the product into a small result FIFO. Finally it presents
// the FIFO head downstream with a valid/ready handshake. At most one
// multiplication is in flight.
//
// Optional feature (macro MULT_ZERO_BYPASS_EN):
//   When defined, an accepted pair with a zero operand skips the multiplier.
//   The FSM goes straight from IDLE to CAPTURE and pushes 0, with no start
//   pulse. When undefined, zero operands take the normal multiplier path.
//
// Parameters:
//   WIDTH        operand width; products are 2*WIDTH wide
//   MUL_LATENCY  cycles from the start pulse cycle to the cycle in which the
//                product is valid (>=1)
//   FIFO_DEPTH   result FIFO entries (>=1)
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   in_valid_i     operand pair valid
//   in_ready_o     block can accept an operand pair
//   in_a_i         multiplier operand
//   in_b_i         multiplicand operand
//   mul_start_o    one-cycle start pulse to the multiplier
//   mul_a_o        registered operand a to the multiplier
//   mul_b_o        registered operand b to the multiplier
//   mul_product_i  product returned by the multiplier
//   out_valid_o    FIFO head valid
//   out_ready_i    downstream accepts the head
//   out_product_o  FIFO head product (0 when empty)
//   busy_o         an operation is in flight
module mult_stream_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 34,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  output logic               mul_start_o,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic [2*WIDTH-1:0] mul_product_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] out_product_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(MUL_LATENCY) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               zero_hold;
  logic               zero_op;
  logic               accept;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] push_data;

  logic [2*WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   fifo_count;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (in_a_i == '0) || (in_b_i == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Space is checked only at accept. While an op is in flight the FIFO can
  // only drain, so the later CAPTURE push always has room.
  assign in_ready_o  = !rst_i && (state == S_IDLE) && (fifo_count < OCC_FULL);
  assign accept      = in_valid_i && in_ready_o;
  assign mul_start_o = (state == S_START);
  assign busy_o      = (state != S_IDLE);
  assign push        = (state == S_CAPTURE);
  assign out_valid_o = (fifo_count != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign push_data   = zero_hold ? '0 : mul_product_i;

  assign out_product_o = out_valid_o ? fifo_mem[rd_ptr] : '0;

  // Operation sequencer. The START edge loads MUL_LATENCY-1. WAIT hands over
  // to CAPTURE on the edge where the counter steps from 1 to 0. This places
  // CAPTURE exactly MUL_LATENCY cycles after the start pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      mul_a_o   <= '0;
      mul_b_o   <= '0;
      zero_hold <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_a_o   <= in_a_i;
            mul_b_o   <= in_b_i;
            zero_hold <= zero_op;
            state     <= zero_op ? S_CAPTURE : S_START;
          end
        end
        S_START: begin
          wait_cnt <= CNT_LOAD;
          state    <= (MUL_LATENCY == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_ONE) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          zero_hold <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result storage. It is left unreset because the head is masked to zero
  // whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the
  // occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
